// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low glyph
// patterns (bit 0 = segment a), the blank pattern, and the dwell states.
package seg_pkg;

   localparam int SETTLE_DEFAULT = 4;

   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_F = 7'h0E;

   localparam logic [6:0] BLANK_PAT = 7'h7F;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_STABLE = 2'd1,
      ST_DONE   = 2'd2
   } dwell_e;

   function automatic logic [2:0] count_low(input logic [3:0] an);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) n = n + {2'b00, ~an[i]};
      return n;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps an active-low a..g pattern to its hex nibble; flags blank and
// patterns that are not one of the sixteen hex glyphs.
module seg7_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] pattern_i,
   output logic       known_o,
   output logic       blank_o,
   output logic [3:0] nibble_o
);

   always_comb begin
      known_o  = 1'b1;
      blank_o  = 1'b0;
      nibble_o = 4'h0;
      case (pattern_i)
         GLYPH_0:   nibble_o = 4'h0;
         GLYPH_1:   nibble_o = 4'h1;
         GLYPH_2:   nibble_o = 4'h2;
         GLYPH_3:   nibble_o = 4'h3;
         GLYPH_4:   nibble_o = 4'h4;
         GLYPH_5:   nibble_o = 4'h5;
         GLYPH_6:   nibble_o = 4'h6;
         GLYPH_7:   nibble_o = 4'h7;
         GLYPH_8:   nibble_o = 4'h8;
         GLYPH_9:   nibble_o = 4'h9;
         GLYPH_A:   nibble_o = 4'hA;
         GLYPH_B:   nibble_o = 4'hB;
         GLYPH_C:   nibble_o = 4'hC;
         GLYPH_D:   nibble_o = 4'hD;
         GLYPH_E:   nibble_o = 4'hE;
         GLYPH_F:   nibble_o = 4'hF;
         BLANK_PAT: blank_o  = 1'b1;
         default:   known_o  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reconstructs a 4-digit hex value by watching a multiplexed active-low
// seven-segment display: each digit is captured once it has dwelt SETTLE cycles.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int SETTLE = SETTLE_DEFAULT
) (
   input  logic        clk,
   input  logic        RST_n,
   input  logic [3:0]  AN,
   input  logic [7:0]  SEGMENT,
   output logic [15:0] HEXS,
   output logic [3:0]  points,
   output logic [3:0]  blank,
   output logic        frame,
   output logic        valid,
   output logic [1:0]  err,
   output logic [1:0]  dbg_state_o
);

   localparam logic [7:0] CNT_MAX = 8'(SETTLE);
   localparam logic [7:0] CNT_ARM = 8'(SETTLE - 1);

   logic [3:0]  an_q, an_p_q;
   logic [7:0]  seg_q, seg_p_q;
   logic [7:0]  cnt_q, cnt_d;
   dwell_e      state_q;
   logic [15:0] stg_nib_q, stg_nib_d;
   logic [3:0]  stg_pt_q, stg_pt_d, stg_blk_q, stg_blk_d;
   logic [3:0]  mask_q, mask_d;
   logic [15:0] hexs_q, hexs_d;
   logic [3:0]  points_q, points_d, blank_q, blank_d;
   logic        frame_q, frame_d, valid_q, valid_d;
   logic [1:0]  err_q, err_d;

   logic        sample_chg, settled, one_low, multi_low, capture, mask_full;
   logic [2:0]  n_low;
   logic [3:0]  cap_bit;
   logic        dec_known, dec_blank;
   logic [3:0]  dec_nib;

   seg7_pattern_decode u_dec (
      .pattern_i (seg_q[6:0]),
      .known_o   (dec_known),
      .blank_o   (dec_blank),
      .nibble_o  (dec_nib)
   );

   always_comb begin
      sample_chg = ({an_q, seg_q} != {an_p_q, seg_p_q});
      n_low      = count_low(an_q);
      one_low    = (n_low == 3'd1);
      multi_low  = (n_low > 3'd1);
      settled    = !sample_chg && (cnt_q == CNT_ARM);
      capture    = (state_q == ST_STABLE) && !sample_chg && one_low && dec_known;
      cap_bit    = capture ? ~an_q : 4'h0;
      mask_full  = (mask_q == 4'hF);
   end

   always_comb begin
      cnt_d     = sample_chg ? 8'd0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1);
      stg_nib_d = stg_nib_q;
      stg_pt_d  = stg_pt_q;
      stg_blk_d = stg_blk_q;
      for (int i = 0; i < 4; i++) begin
         if (cap_bit[i]) begin
            stg_nib_d[4*i +: 4] = dec_nib;
            stg_pt_d[i]         = ~seg_q[7];
            stg_blk_d[i]        = dec_blank;
         end
      end
      // A capture landing on the clearing cycle starts the next frame's mask.
      mask_d   = (mask_full ? 4'h0 : mask_q) | cap_bit;
      hexs_d   = mask_full ? stg_nib_q : hexs_q;
      points_d = mask_full ? stg_pt_q : points_q;
      blank_d  = mask_full ? stg_blk_q : blank_q;
      frame_d  = mask_full;
      valid_d  = valid_q | mask_full;
      err_d    = err_q | {settled && (state_q == ST_WAIT) && multi_low,
                          (state_q == ST_STABLE) && !sample_chg && one_low && !dec_known};
   end

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         an_q      <= 4'hF;
         seg_q     <= 8'hFF;
         an_p_q    <= 4'hF;
         seg_p_q   <= 8'hFF;
         cnt_q     <= 8'd0;
         stg_nib_q <= 16'h0;
         stg_pt_q  <= 4'h0;
         stg_blk_q <= 4'h0;
         mask_q    <= 4'h0;
         hexs_q    <= 16'h0;
         points_q  <= 4'h0;
         blank_q   <= 4'h0;
         frame_q   <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 2'b00;
      end else begin
         an_q      <= AN;
         seg_q     <= SEGMENT;
         an_p_q    <= an_q;
         seg_p_q   <= seg_q;
         cnt_q     <= cnt_d;
         stg_nib_q <= stg_nib_d;
         stg_pt_q  <= stg_pt_d;
         stg_blk_q <= stg_blk_d;
         mask_q    <= mask_d;
         hexs_q    <= hexs_d;
         points_q  <= points_d;
         blank_q   <= blank_d;
         frame_q   <= frame_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= ST_WAIT;
      end else if (sample_chg) begin
         state_q <= ST_WAIT;
      end else begin
         case (state_q)
            ST_WAIT:   if (settled && one_low) state_q <= ST_STABLE;
            ST_STABLE: state_q <= ST_DONE;
            ST_DONE:   state_q <= ST_DONE;
            default:   state_q <= ST_WAIT;
         endcase
      end
   end

   assign HEXS        = hexs_q;
   assign points      = points_q;
   assign blank       = blank_q;
   assign frame       = frame_q;
   assign valid       = valid_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scan scenarios plus random dwell and
// pattern sequences, checked every cycle against a pin-level reference model.
module tb_seg_scan_decoder;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        RST_n;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic [15:0] HEXS;
   logic [3:0]  points, blank;
   logic        frame, valid;
   logic [1:0]  err;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   seg_scan_decoder #(.SETTLE(S)) dut (
      .clk         (clk),
      .RST_n       (RST_n),
      .AN          (an),
      .SEGMENT     (seg),
      .HEXS        (HEXS),
      .points      (points),
      .blank       (blank),
      .frame       (frame),
      .valid       (valid),
      .err         (err),
      .dbg_state_o (dbg_state)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int n_frames = 0;
   bit beef_mode = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: active-low hex glyph table and display state.
   logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [3:0]  stg_nib [4];
   logic [3:0]  stg_pt, stg_blk, m_mask;
   logic [15:0] m_hexs;
   logic [3:0]  m_points, m_blank;
   logic        m_frame, m_valid;
   logic [1:0]  m_err;
   bit          frame_pend, cap_pend, err1_pend;
   logic [11:0] prev_pin, cap_pin;
   int          run_len;

   function automatic int lows(input logic [3:0] a);
      int n;
      n = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) n++;
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) stg_nib[i] = 4'h0;
      stg_pt = 0; stg_blk = 0; m_mask = 0;
      m_hexs = 0; m_points = 0; m_blank = 0;
      m_frame = 0; m_valid = 0; m_err = 0;
      frame_pend = 0; cap_pend = 0; err1_pend = 0;
      prev_pin = 12'hFFF; cap_pin = 12'hFFF; run_len = 0;
   endtask

   // One rising edge: pin values must hold SETTLE+2 edges for a capture,
   // whose effect lands on the following edge; a full mask loads one edge later.
   task automatic model_edge();
      int d;
      bit known, blk;
      logic [3:0] nib;
      logic [11:0] pin;
      m_frame = 1'b0;
      if (frame_pend) begin
         for (int i = 0; i < 4; i++) m_hexs[4*i +: 4] = stg_nib[i];
         m_points = stg_pt;
         m_blank  = stg_blk;
         m_frame  = 1'b1;
         m_valid  = 1'b1;
         m_mask   = 4'h0;
      end
      if (cap_pend) begin
         d = 0;
         for (int i = 0; i < 4; i++) if (!cap_pin[8+i]) d = i;
         known = 0; blk = 0; nib = 4'h0;
         if (cap_pin[6:0] == 7'h7F) begin
            known = 1; blk = 1;
         end else begin
            for (int g = 0; g < 16; g++) if (glyph[g] == cap_pin[6:0]) begin
               known = 1; nib = 4'(g);
            end
         end
         if (known) begin
            stg_nib[d] = nib;
            stg_pt[d]  = ~cap_pin[7];
            stg_blk[d] = blk;
            m_mask[d]  = 1'b1;
         end else begin
            m_err[0] = 1'b1;
         end
      end
      if (err1_pend) m_err[1] = 1'b1;
      frame_pend = (m_mask == 4'hF);
      pin = {an, seg};
      if (pin == prev_pin) run_len++;
      else run_len = 1;
      prev_pin  = pin;
      cap_pend  = (run_len == S + 2) && (lows(an) == 1);
      cap_pin   = pin;
      err1_pend = (run_len == S + 1) && (lows(an) > 1);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (frame) n_frames++;
      if (frame && beef_mode) check_eq("beef_hexs", 32'(HEXS), 32'h0000BEEF);
      check_eq("frame",  32'(frame),  32'(m_frame));
      check_eq("hexs",   32'(HEXS),   32'(m_hexs));
      check_eq("points", 32'(points), 32'(m_points));
      check_eq("blank",  32'(blank),  32'(m_blank));
      check_eq("valid",  32'(valid),  32'(m_valid));
      check_eq("err",    32'(err),    32'(m_err));
   endtask

   task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      RST_n = 1'b0;
      an    = 4'hF;
      seg   = 8'hFF;
      model_reset();
      #1;
      check_eq("rst_hexs",   32'(HEXS),      32'h0);
      check_eq("rst_points", 32'(points),    32'h0);
      check_eq("rst_blank",  32'(blank),     32'h0);
      check_eq("rst_frame",  32'(frame),     32'h0);
      check_eq("rst_valid",  32'(valid),     32'h0);
      check_eq("rst_err",    32'(err),       32'h0);
      check_eq("rst_state",  32'(dbg_state), 32'h0);
      @(negedge clk);
      RST_n = 1'b1;
   endtask

   initial begin
      int f0, dwell, r;
      logic [3:0] a;
      logic [7:0] s;
      RST_n = 1'b1;
      an    = 4'hF;
      seg   = 8'hFF;
      @(negedge clk);
      do_reset();

      // Basic scan of 0123.
      f0 = n_frames;
      hold(4'b1110, 8'hB0, 8); hold(4'b1101, 8'hA4, 8);
      hold(4'b1011, 8'hF9, 8); hold(4'b0111, 8'hC0, 8);
      hold(4'hF, 8'hFF, 4);
      check_eq("scan_frames", 32'(n_frames - f0), 32'd1);
      check_eq("scan_hexs",   32'(HEXS),  32'h0123);
      check_eq("scan_valid",  32'(valid), 32'd1);
      check_eq("scan_err",    32'(err),   32'd0);

      // Digit 2 too short, then completed with A.
      f0 = n_frames;
      hold(4'b1110, 8'hB0, 8); hold(4'b1101, 8'hA4, 8);
      hold(4'b1011, 8'h88, 3); hold(4'b0111, 8'hC0, 8);
      hold(4'hF, 8'hFF, 4);
      check_eq("short_frames", 32'(n_frames - f0), 32'd0);
      hold(4'b1011, 8'h88, 8); hold(4'hF, 8'hFF, 4);
      check_eq("short_done_frames", 32'(n_frames - f0), 32'd1);
      check_eq("short_done_hexs",   32'(HEXS), 32'h0A23);

      // Digit 1 blank with its point lit.
      hold(4'b1110, 8'hB0, 8); hold(4'b1101, 8'h7F, 8);
      hold(4'b1011, 8'hF9, 8); hold(4'b0111, 8'hC0, 8);
      hold(4'hF, 8'hFF, 4);
      check_eq("blank_blank",  32'(blank),     32'b0010);
      check_eq("blank_points", 32'(points),    32'b0010);
      check_eq("blank_nib",    32'(HEXS[7:4]), 32'h0);

      // Unknown pattern, then multiple enables.
      do_reset();
      f0 = n_frames;
      hold(4'b1110, 8'hB0, 8); hold(4'b1101, 8'hA4, 8);
      hold(4'b1011, 8'hF9, 8); hold(4'b0111, 8'hFE, 8);
      hold(4'hF, 8'hFF, 4);
      check_eq("unk_err",    32'(err), 32'b01);
      check_eq("unk_frames", 32'(n_frames - f0), 32'd0);
      hold(4'b0111, 8'hC0, 8); hold(4'hF, 8'hFF, 4);
      check_eq("unk_fix_frames", 32'(n_frames - f0), 32'd1);
      check_eq("unk_fix_hexs",   32'(HEXS), 32'h0123);
      hold(4'b1100, 8'hC0, 8); hold(4'hF, 8'hFF, 4);
      check_eq("multi_err", 32'(err), 32'b11);

      // Reset after three captures discards them.
      do_reset();
      hold(4'b1110, 8'hB0, 8); hold(4'b1101, 8'hA4, 8); hold(4'b1011, 8'hF9, 8);
      do_reset();
      f0 = n_frames;
      hold(4'b0111, 8'hC0, 8); hold(4'hF, 8'hFF, 4);
      check_eq("midrst_frames", 32'(n_frames - f0), 32'd0);
      hold(4'b1110, 8'hB0, 8); hold(4'b1101, 8'hA4, 8); hold(4'b1011, 8'hF9, 8);
      hold(4'hF, 8'hFF, 4);
      check_eq("midrst_done_frames", 32'(n_frames - f0), 32'd1);
      check_eq("midrst_done_hexs",   32'(HEXS), 32'h0123);

      // Three continuous rounds of BEEF.
      beef_mode = 1'b1;
      f0 = n_frames;
      repeat (3) begin
         hold(4'b1110, 8'h8E, 8); hold(4'b1101, 8'h86, 8);
         hold(4'b1011, 8'h86, 8); hold(4'b0111, 8'h83, 8);
      end
      beef_mode = 1'b0;
      check_eq("beef_frames", 32'(n_frames - f0), 32'd3);

      // Random dwell lengths, glyphs, points, blanks and junk.
      do_reset();
      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 19);
         a = 4'hF;
         a[$urandom_range(0, 3)] = 1'b0;
         if (r == 0) a = 4'hF;
         if (r == 1) a = 4'($urandom_range(0, 15));
         s = {($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1, glyph[$urandom_range(0, 15)]};
         if (r == 2) s = 8'($urandom_range(0, 255));
         if (r == 3) s[6:0] = 7'h7F;
         dwell = $urandom_range(2, 10);
         hold(a, s, dwell);
      end
      hold(4'hF, 8'hFF, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
